// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard control: operand forwarding, load-use stall, branch flush, multicycle MUL sequencing
module hazard_ctrl #(
    parameter int XLEN       = 32,
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 3,
    parameter int MUL_LAT    = 4,
    localparam int FW        = $clog2(FWD_STAGES + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         id_valid,
    input  logic [REG_AW-1:0]            id_rs1,
    input  logic [REG_AW-1:0]            id_rs2,
    input  logic                         id_use_rs1,
    input  logic                         id_use_rs2,
    input  logic                         id_is_mul,
    input  logic [FWD_STAGES*REG_AW-1:0] stg_rd,
    input  logic [FWD_STAGES-1:0]        stg_wb_en,
    input  logic                         ex_is_load,
    input  logic                         br_taken,
    output logic [FW-1:0]                fwd1_sel,
    output logic [FW-1:0]                fwd2_sel,
    output logic                         stall_if,
    output logic                         stall_id,
    output logic                         flush_id,
    output logic                         flush_ex,
    output logic                         mul_start,
    output logic                         mul_busy,
    output logic                         mul_done,
    output logic [15:0]                  stall_cnt
);

    localparam int CW = 4;

    if (MUL_LAT < 2 || MUL_LAT > 16 || XLEN < 1 || FWD_STAGES < 1) begin : g_bad_param
        $error("hazard_ctrl: illegal parameter value");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_nxt;
    logic [FWD_STAGES-1:0] match1;
    logic [FWD_STAGES-1:0] match2;
    logic [FW-1:0]         sel1;
    logic [FW-1:0]         sel2;
    logic                  busy;
    logic                  load_use;
    logic                  accept;

    always_comb begin
        match1 = '0;
        match2 = '0;
        for (int k = 0; k < FWD_STAGES; k++) begin
            match1[k] = (stg_rd[k*REG_AW +: REG_AW] == id_rs1) && (id_rs1 != '0)
                        && stg_wb_en[k] && id_use_rs1;
            match2[k] = (stg_rd[k*REG_AW +: REG_AW] == id_rs2) && (id_rs2 != '0)
                        && stg_wb_en[k] && id_use_rs2;
        end
    end

    // Scan from the oldest stage down so the nearest matching stage overrides.
    always_comb begin
        sel1 = '0;
        sel2 = '0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (match1[k]) sel1 = FW'(k + 1);
            if (match2[k]) sel2 = FW'(k + 1);
        end
    end

    // Every combinational control is gated by rst so nothing leaks out while in reset.
    assign busy     = (state == BUSY);
    assign load_use = rst && id_valid && ex_is_load && (match1[0] || match2[0])
                      && !br_taken && !busy;
    assign accept   = rst && id_valid && id_is_mul && !load_use && !br_taken && !busy;

    assign stall_if = rst && (busy || load_use);
    assign stall_id = rst && (busy || load_use);
    assign flush_ex = rst && !busy && (load_use || br_taken);
    assign flush_id = rst && !busy && br_taken;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CW'(MUL_LAT - 1);
                end else begin
                    state_nxt = IDLE;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            fwd1_sel  <= '0;
            fwd2_sel  <= '0;
            mul_start <= 1'b0;
            mul_busy  <= 1'b0;
            mul_done  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            mul_start <= accept;
            mul_busy  <= (state_nxt == BUSY);
            mul_done  <= (state_nxt == DONE);
            // A bubble into EX has no operands to forward; a held ID keeps its selects.
            if (flush_ex) begin
                fwd1_sel <= '0;
                fwd2_sel <= '0;
            end else if (!stall_id) begin
                fwd1_sel <= sel1;
                fwd2_sel <= sel2;
            end
            if (stall_id && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with directed vectors
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic        id_is_mul;
    logic [14:0] stg_rd;
    logic [2:0]  stg_wb_en;
    logic        ex_is_load;
    logic        br_taken;
    logic [1:0]  fwd1_sel;
    logic [1:0]  fwd2_sel;
    logic        stall_if;
    logic        stall_id;
    logic        flush_id;
    logic        flush_ex;
    logic        mul_start;
    logic        mul_busy;
    logic        mul_done;
    logic [15:0] stall_cnt;

    hazard_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .id_is_mul  (id_is_mul),
        .stg_rd     (stg_rd),
        .stg_wb_en  (stg_wb_en),
        .ex_is_load (ex_is_load),
        .br_taken   (br_taken),
        .fwd1_sel   (fwd1_sel),
        .fwd2_sel   (fwd2_sel),
        .stall_if   (stall_if),
        .stall_id   (stall_id),
        .flush_id   (flush_id),
        .flush_ex   (flush_ex),
        .mul_start  (mul_start),
        .mul_busy   (mul_busy),
        .mul_done   (mul_done),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          cyc;
        logic [1:0]  f1;
        logic [1:0]  f2;
        logic        st;
        logic        fi;
        logic        fe;
        logic        ms;
        logic        mb;
        logic        md;
        logic [15:0] sc;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_miss = 0;

    always @(posedge clk) cyc++;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic mul,
                          input logic ld, input logic br,
                          input logic [4:0] rd_wb, input logic [4:0] rd_mem,
                          input logic [4:0] rd_ex, input logic [2:0] wb);
        id_valid   = v;
        id_rs1     = rs1;
        id_rs2     = rs2;
        id_use_rs1 = u1;
        id_use_rs2 = u2;
        id_is_mul  = mul;
        ex_is_load = ld;
        br_taken   = br;
        stg_rd     = {rd_wb, rd_mem, rd_ex};
        stg_wb_en  = wb;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    endtask

    task automatic chk(input string name, input logic [1:0] f1, input logic [1:0] f2,
                       input logic st, input logic fi, input logic fe,
                       input logic ms, input logic mb, input logic md,
                       input logic [15:0] sc);
        exp_t e;
        e.name = name; e.cyc = cyc;
        e.f1 = f1; e.f2 = f2; e.st = st; e.fi = fi; e.fe = fe;
        e.ms = ms; e.mb = mb; e.md = md; e.sc = sc;
        q.push_back(e);
    endtask

    // Monitor: compares every expectation tagged for the current cycle, mid-cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            if (e.cyc != cyc || fwd1_sel !== e.f1 || fwd2_sel !== e.f2 ||
                stall_if !== e.st || stall_id !== e.st || flush_id !== e.fi ||
                flush_ex !== e.fe || mul_start !== e.ms || mul_busy !== e.mb ||
                mul_done !== e.md || stall_cnt !== e.sc) begin
                n_miss++;
                $display("FAIL %s (cyc %0d/%0d): got f1=%0d f2=%0d sif=%b sid=%b fid=%b fex=%b ms=%b mb=%b md=%b sc=%h; want f1=%0d f2=%0d st=%b fid=%b fex=%b ms=%b mb=%b md=%b sc=%h",
                         e.name, cyc, e.cyc, fwd1_sel, fwd2_sel, stall_if, stall_id,
                         flush_id, flush_ex, mul_start, mul_busy, mul_done, stall_cnt,
                         e.f1, e.f2, e.st, e.fi, e.fe, e.ms, e.mb, e.md, e.sc);
            end
        end
    end

    initial begin
        #1_000_000;
        n_miss++;
        $display("FAIL watchdog: got timeout at cycle %0d, want completion", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        rst = 1'b0;
        set_in(1, 0, 3, 0, 1, 1, 1, 1, 0, 0, 3, 3'b111);
        next_cycle();
        chk("reset_comb_gated", 0, 0, 0, 0, 0, 0, 0, 0, 16'd0);

        next_cycle();
        rst = 1'b1;
        idle();
        chk("post_reset", 0, 0, 0, 0, 0, 0, 0, 0, 16'd0);

        next_cycle();
        set_in(1, 5, 0, 1, 0, 0, 0, 0, 5, 5, 7, 3'b111);
        chk("fwd_setup", 0, 0, 0, 0, 0, 0, 0, 0, 16'd0);

        next_cycle();
        set_in(1, 0, 7, 1, 1, 0, 0, 0, 5, 5, 7, 3'b111);
        chk("fwd1_nearest_mem", 2, 0, 0, 0, 0, 0, 0, 0, 16'd0);

        next_cycle();
        set_in(1, 5, 7, 1, 0, 0, 0, 0, 5, 9, 7, 3'b111);
        chk("fwd1_x0_fwd2_ex", 0, 1, 0, 0, 0, 0, 0, 0, 16'd0);

        next_cycle();
        set_in(1, 5, 7, 1, 0, 0, 0, 0, 5, 9, 7, 3'b011);
        chk("fwd1_wb_fwd2_unused", 3, 0, 0, 0, 0, 0, 0, 0, 16'd0);

        next_cycle();
        idle();
        chk("fwd1_wben_off", 0, 0, 0, 0, 0, 0, 0, 0, 16'd0);

        next_cycle();
        set_in(1, 0, 3, 0, 1, 0, 1, 0, 0, 0, 3, 3'b111);
        chk("load_use_stall", 0, 0, 1, 0, 1, 0, 0, 0, 16'd0);

        next_cycle();
        set_in(1, 0, 3, 0, 1, 0, 0, 0, 0, 3, 0, 3'b110);
        chk("load_use_one_cycle", 0, 0, 0, 0, 0, 0, 0, 0, 16'd1);

        next_cycle();
        idle();
        chk("fwd2_mem_after_load", 0, 2, 0, 0, 0, 0, 0, 0, 16'd1);

        next_cycle();
        set_in(1, 0, 3, 0, 1, 0, 1, 1, 0, 0, 3, 3'b111);
        chk("branch_beats_load_use", 0, 0, 0, 1, 1, 0, 0, 0, 16'd1);

        next_cycle();
        set_in(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 3'b000);
        chk("branch_kills_mul", 0, 0, 0, 1, 1, 0, 0, 0, 16'd1);

        next_cycle();
        idle();
        chk("no_mul_start", 0, 0, 0, 0, 0, 0, 0, 0, 16'd1);

        next_cycle();
        set_in(1, 5, 0, 1, 0, 1, 0, 0, 0, 0, 5, 3'b111);
        chk("mul_accept", 0, 0, 0, 0, 0, 0, 0, 0, 16'd1);

        next_cycle();
        set_in(1, 5, 0, 1, 0, 0, 0, 0, 0, 5, 0, 3'b111);
        chk("mul_start_busy1", 1, 0, 1, 0, 0, 1, 1, 0, 16'd1);

        next_cycle();
        set_in(1, 0, 3, 0, 1, 0, 1, 1, 0, 0, 3, 3'b111);
        chk("busy2_ignores_br_lu", 1, 0, 1, 0, 0, 0, 1, 0, 16'd2);

        next_cycle();
        idle();
        chk("busy3", 1, 0, 1, 0, 0, 0, 1, 0, 16'd3);

        next_cycle();
        idle();
        chk("busy4", 1, 0, 1, 0, 0, 0, 1, 0, 16'd4);

        next_cycle();
        set_in(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3'b000);
        chk("mul_done_b2b_accept", 1, 0, 0, 0, 0, 0, 0, 1, 16'd5);

        next_cycle();
        idle();
        chk("b2b_start", 0, 0, 1, 0, 0, 1, 1, 0, 16'd5);

        next_cycle();
        rst = 1'b0;
        set_in(1, 0, 3, 0, 1, 1, 1, 1, 0, 0, 3, 3'b111);
        chk("reset_mid_busy", 0, 0, 0, 0, 0, 0, 0, 0, 16'd0);

        next_cycle();
        rst = 1'b1;
        idle();
        chk("after_release", 0, 0, 0, 0, 0, 0, 0, 0, 16'd0);

        for (int i = 0; i < 3; i++) begin
            next_cycle();
            chk("no_done_after_abort", 0, 0, 0, 0, 0, 0, 0, 0, 16'd0);
        end

        next_cycle();
        set_in(1, 0, 3, 0, 1, 0, 1, 0, 0, 0, 3, 3'b111);
        chk("sat_start", 0, 0, 1, 0, 1, 0, 0, 0, 16'd0);
        for (int n = 1; n <= 70000; n++) begin
            next_cycle();
            if (n == 65534) chk("sat_minus_one", 0, 0, 1, 0, 1, 0, 0, 0, 16'hFFFE);
            if (n == 65535) chk("sat_reached", 0, 0, 1, 0, 1, 0, 0, 0, 16'hFFFF);
            if (n == 70000) chk("sat_holds", 0, 0, 1, 0, 1, 0, 0, 0, 16'hFFFF);
        end

        next_cycle();
        idle();
        next_cycle();
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
